uart_rx: RTL and testbench

UART receiver for the SDRAM loopback path. It samples the asynchronous rs232_rx line in the 50 MHz sclk domain and deserialises 8N1 frames, LSB first. Each good byte is pushed into the SDRAM write-side FIFO with a single-cycle write strobe. It is the counterpart of the FIFO-fed transmitter: same baud constants, same frame format.

---
 rtl/uart_rx.sv | 172 +++++++++++++++++
 tb/tb_uart_rx.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver pushing good bytes into the SDRAM write FIFO.
// Define UART_RX_PARITY_EN for 8E1 frames with parity_err reporting.
module uart_rx #(
   parameter int BAUD_END = 5207,
   parameter int BAUD_M   = BAUD_END / 2 - 1,
`ifdef UART_RX_PARITY_EN
   parameter int BIT_END  = 10
`else
   parameter int BIT_END  = 9
`endif
) (
   input  logic       sclk,
   input  logic       s_rst_n,
   input  logic       rs232_rx,
   input  logic       wfifo_full,
   output logic       wfifo_wr_en,
   output logic [7:0] wfifo_wr_data,
   output logic       frame_err,
   output logic       overflow,
   output logic       parity_err
);

   localparam int            BW     = $clog2(BAUD_END + 1);
   localparam logic [BW-1:0] B_END  = BW'(BAUD_END);
   localparam logic [BW-1:0] B_MID  = BW'(BAUD_M);
   localparam logic [3:0]    B_STOP = 4'(BIT_END);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
      PARITY = 3'd4,
`endif
      STOP   = 3'd3
   } state_t;

   state_t        state, state_nxt;
   logic          rx_r1, rx_r2, rx_r3;
   logic [2:0]    arm;
   logic [BW-1:0] baud_cnt;
   logic [3:0]    bit_cnt;
   logic [7:0]    shift;
   logic [2:0]    bit_idx;
   logic          start_edge;
   logic          bit_flag;
   logic          stop_smp;
   logic          frame_ok;

   always_ff @(posedge sclk or negedge s_rst_n) begin
      if (!s_rst_n) begin
         rx_r1 <= 1'b1;
         rx_r2 <= 1'b1;
         rx_r3 <= 1'b1;
         arm   <= 3'b000;
      end else begin
         rx_r1 <= rs232_rx;
         rx_r2 <= rx_r1;
         rx_r3 <= rx_r2;
         arm   <= {arm[1:0], 1'b1};
      end
   end

   // rx_r3 only holds a real line sample once the chain has refilled after
   // reset; a line already low at release must not look like a start edge.
   assign start_edge = arm[2] & rx_r3 & ~rx_r2;
   assign bit_flag   = (state != IDLE) && (baud_cnt == B_MID);
   assign stop_smp   = (state == STOP) && bit_flag;
   assign bit_idx    = bit_cnt[2:0] - 3'd1;

   always_ff @(posedge sclk or negedge s_rst_n) begin
      if (!s_rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (start_edge) state_nxt = START;
         end
         START: begin
            if (bit_flag) state_nxt = rx_r2 ? IDLE : DATA;
         end
         DATA: begin
`ifdef UART_RX_PARITY_EN
            if (bit_flag && bit_cnt == 4'd8) state_nxt = PARITY;
`else
            if (bit_flag && bit_cnt == 4'd8) state_nxt = STOP;
`endif
         end
`ifdef UART_RX_PARITY_EN
         PARITY: begin
            if (bit_flag) state_nxt = STOP;
         end
`endif
         STOP: begin
            if (bit_flag && bit_cnt == B_STOP) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge sclk or negedge s_rst_n) begin
      if (!s_rst_n) begin
         baud_cnt <= '0;
         bit_cnt  <= 4'd0;
      end else if (state == IDLE) begin
         baud_cnt <= '0;
         bit_cnt  <= 4'd0;
      end else begin
         baud_cnt <= (baud_cnt == B_END) ? '0 : baud_cnt + 1'b1;
         if (bit_flag) bit_cnt <= bit_cnt + 4'd1;
      end
   end

   always_ff @(posedge sclk or negedge s_rst_n) begin
      if (!s_rst_n) begin
         shift <= 8'h00;
      end else if (state == DATA && bit_flag) begin
         shift[bit_idx] <= rx_r2;
      end
   end

`ifdef UART_RX_PARITY_EN
   logic par_bit;
   logic par_bad;

   always_ff @(posedge sclk or negedge s_rst_n) begin
      if (!s_rst_n) begin
         par_bit <= 1'b0;
      end else if (state == PARITY && bit_flag) begin
         par_bit <= rx_r2;
      end
   end

   assign par_bad  = par_bit ^ (^shift);
   assign frame_ok = rx_r2 & ~par_bad;

   // A bad stop bit outranks a parity mismatch.
   always_ff @(posedge sclk or negedge s_rst_n) begin
      if (!s_rst_n) begin
         parity_err <= 1'b0;
      end else begin
         parity_err <= stop_smp & rx_r2 & par_bad;
      end
   end
`else
   assign frame_ok   = rx_r2;
   assign parity_err = 1'b0;
`endif

   always_ff @(posedge sclk or negedge s_rst_n) begin
      if (!s_rst_n) begin
         wfifo_wr_en   <= 1'b0;
         wfifo_wr_data <= 8'h00;
         frame_err     <= 1'b0;
         overflow      <= 1'b0;
      end else begin
         wfifo_wr_en <= stop_smp & frame_ok & ~wfifo_full;
         overflow    <= stop_smp & frame_ok & wfifo_full;
         frame_err   <= stop_smp & ~rx_r2;
         if (stop_smp && frame_ok && !wfifo_full) begin
            wfifo_wr_data <= shift;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames against an event-queue model of uart_rx.
// Builds for 8N1 by default, 8E1 when UART_RX_PARITY_EN is defined.
module tb_uart_rx;

   localparam int BE  = 28;
   localparam int BP  = BE + 1;
   localparam int BM  = BE / 2 - 1;
`ifdef UART_RX_PARITY_EN
   localparam int NB  = 10;
`else
   localparam int NB  = 9;
`endif
   // pin fall to strobe: 2 sync + NB bit periods + half bit + 2
   localparam int LAT = 2 + NB * BP + BM + 2;

   localparam int K_WR   = 0;
   localparam int K_OVF  = 1;
   localparam int K_FERR = 2;
   localparam int K_PERR = 3;

   typedef struct {
      int         kind;
      logic [7:0] data;
      int         t;
   } ev_t;

   logic       sclk;
   logic       s_rst_n;
   logic       rs232_rx;
   logic       wfifo_full;
   logic       wfifo_wr_en;
   logic [7:0] wfifo_wr_data;
   logic       frame_err;
   logic       overflow;
   logic       parity_err;

   int         cyc;
   int         n_chk;
   int         n_fail;
   int         n_wr;
   int         n_ovf;
   int         n_ferr;
   int         n_perr;
   int         last_wr_cyc;
   logic [7:0] last_data;
   ev_t        q[$];

   uart_rx #(.BAUD_END(BE)) dut (
      .sclk          (sclk),
      .s_rst_n       (s_rst_n),
      .rs232_rx      (rs232_rx),
      .wfifo_full    (wfifo_full),
      .wfifo_wr_en   (wfifo_wr_en),
      .wfifo_wr_data (wfifo_wr_data),
      .frame_err     (frame_err),
      .overflow      (overflow),
      .parity_err    (parity_err)
   );

   initial sclk = 1'b0;
   always #10 sclk = ~sclk;

   initial cyc = 0;
   always @(posedge sclk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                  nm, act, exp, cyc);
      end
   endtask

   task automatic chk_rng(input string nm, input int act,
                          input int lo, input int hi);
      n_chk++;
      if (act < lo || act > hi) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
      end
   endtask

   // Called on a negedge; returns on a negedge with the line idle.
   task automatic send_frame(input logic [7:0] d, input logic stop,
                             input logic par_flip, input bit expect_ev,
                             output int fall);
      ev_t e;
      fall = cyc;
      if (expect_ev) begin
         e.data = d;
         e.t    = cyc + LAT;
         if (!stop)          e.kind = K_FERR;
`ifdef UART_RX_PARITY_EN
         else if (par_flip)  e.kind = K_PERR;
`endif
         else if (wfifo_full) e.kind = K_OVF;
         else                e.kind = K_WR;
         q.push_back(e);
      end
      rs232_rx = 1'b0;
      repeat (BP) @(negedge sclk);
      for (int i = 0; i < 8; i++) begin
         rs232_rx = d[i];
         repeat (BP) @(negedge sclk);
      end
`ifdef UART_RX_PARITY_EN
      rs232_rx = (^d) ^ par_flip;
      repeat (BP) @(negedge sclk);
`endif
      rs232_rx = stop;
      repeat (BP) @(negedge sclk);
      rs232_rx = 1'b1;
   endtask

   task automatic idle_bits(input int n);
      rs232_rx = 1'b1;
      repeat (n * BP) @(negedge sclk);
   endtask

   // Compare process: every cycle, DUT outputs against the event queue.
   always @(negedge sclk) begin
      ev_t        e;
      int         k;
      logic [3:0] p;
      #1;
      if (!s_rst_n) begin
         last_data = 8'h00;
         chk("rst_outputs",
             {28'd0, wfifo_wr_en, overflow, frame_err, parity_err}, 32'd0);
         chk("rst_wr_data", {24'd0, wfifo_wr_data}, 32'd0);
      end else begin
         p = {wfifo_wr_en, overflow, frame_err, parity_err};
         chk("onehot_pulses", ($countones(p) <= 1) ? 32'd1 : 32'd0, 32'd1);
         if (p != 4'd0) begin
            k = wfifo_wr_en ? K_WR : overflow ? K_OVF :
                frame_err ? K_FERR : K_PERR;
            if (k == K_WR)   begin n_wr++; last_wr_cyc = cyc; end
            if (k == K_OVF)  n_ovf++;
            if (k == K_FERR) n_ferr++;
            if (k == K_PERR) n_perr++;
            if (q.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL unexpected_pulse: kind %0d at cycle %0d, none expected",
                        k, cyc);
            end else begin
               e = q.pop_front();
               chk("pulse_kind", k, e.kind);
               chk_rng("pulse_time", cyc, e.t - 1, e.t + 1);
               if (e.kind == K_WR) begin
                  last_data = e.data;
                  chk("wr_data", {24'd0, wfifo_wr_data}, {24'd0, e.data});
               end
            end
         end
         chk("wr_data_held", {24'd0, wfifo_wr_data}, {24'd0, last_data});
         if (q.size() > 0 && cyc > q[0].t + 1) begin
            e = q.pop_front();
            n_chk++;
            n_fail++;
            $display("FAIL missing_pulse: kind %0d due cycle %0d, none by %0d",
                     e.kind, e.t, cyc);
         end
      end
   end

   initial begin
      int fall;
      int dummy;
      n_chk = 0; n_fail = 0;
      n_wr = 0; n_ovf = 0; n_ferr = 0; n_perr = 0;
      last_wr_cyc = 0;
      last_data = 8'h00;
      s_rst_n = 1'b0;
      rs232_rx = 1'b1;
      wfifo_full = 1'b0;
      repeat (5) @(negedge sclk);
      s_rst_n = 1'b1;
      idle_bits(1);
      chk("post_rst_data", {24'd0, wfifo_wr_data}, 32'h0);

      // single byte, then latency pinned by hand
      send_frame(8'h55, 1'b1, 1'b0, 1'b1, fall);
      idle_bits(10);
      chk("lit_data_55", {24'd0, wfifo_wr_data}, 32'h55);
`ifdef UART_RX_PARITY_EN
      chk_rng("lit_latency", last_wr_cyc - fall, 306, 308);
`else
      chk_rng("lit_latency", last_wr_cyc - fall, 277, 279);
`endif
      chk("lit_n_wr_1", n_wr, 1);

      // back-to-back, zero idle
      send_frame(8'hA5, 1'b1, 1'b0, 1'b1, dummy);
      send_frame(8'h3C, 1'b1, 1'b0, 1'b1, dummy);
      send_frame(8'hFF, 1'b1, 1'b0, 1'b1, dummy);
      send_frame(8'h00, 1'b1, 1'b0, 1'b1, dummy);
      idle_bits(3);
      chk("lit_n_wr_5", n_wr, 5);
      chk("lit_data_00", {24'd0, wfifo_wr_data}, 32'h00);

      // 5-cycle low glitch: false start
      rs232_rx = 1'b0;
      repeat (5) @(negedge sclk);
      idle_bits(3);
      chk("lit_glitch_n_wr", n_wr, 5);

      // bad stop bit, then a good byte
      send_frame(8'h81, 1'b0, 1'b0, 1'b1, dummy);
      idle_bits(2);
      send_frame(8'h42, 1'b1, 1'b0, 1'b1, dummy);
      idle_bits(2);
      chk("lit_n_ferr", n_ferr, 1);
      chk("lit_data_42", {24'd0, wfifo_wr_data}, 32'h42);

      // FIFO full drops the byte
      wfifo_full = 1'b1;
      send_frame(8'h7E, 1'b1, 1'b0, 1'b1, dummy);
      idle_bits(1);
      wfifo_full = 1'b0;
      chk("lit_n_ovf", n_ovf, 1);
      chk("lit_data_after_ovf", {24'd0, wfifo_wr_data}, 32'h42);
      send_frame(8'h7E, 1'b1, 1'b0, 1'b1, dummy);
      idle_bits(2);
      chk("lit_data_7e", {24'd0, wfifo_wr_data}, 32'h7E);
      chk("lit_n_wr_7", n_wr, 7);

      // reset pulse inside data bit 4 of 0xC3
      fork
         send_frame(8'hC3, 1'b1, 1'b0, 1'b0, dummy);
         begin
            repeat (BP * 5 + 5) @(negedge sclk);
            s_rst_n = 1'b0;
            repeat (4) @(negedge sclk);
            s_rst_n = 1'b1;
         end
      join
      idle_bits(3);
      chk("lit_n_wr_after_rst", n_wr, 7);
      send_frame(8'h5A, 1'b1, 1'b0, 1'b1, dummy);
      idle_bits(2);
      chk("lit_data_5a", {24'd0, wfifo_wr_data}, 32'h5A);
      chk("lit_n_wr_8", n_wr, 8);

`ifdef UART_RX_PARITY_EN
      send_frame(8'h01, 1'b1, 1'b1, 1'b1, dummy);
      idle_bits(2);
      chk("lit_n_perr", n_perr, 1);
      chk("lit_n_wr_perr", n_wr, 8);
`else
      chk("lit_n_perr", n_perr, 0);
`endif

      idle_bits(2);
      chk("queue_drained", q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
